// File: rtl/divider_monitor_pkg.sv
// ----------------------------------------------------------------------------
// divider_monitor_pkg
//
// Shared definitions for the divider monitor: the measurement FSM state
// encoding, the default counter width, the lock-counter width and a small
// saturating-increment helper for the lock counter.
//
// No ports (package).
// ----------------------------------------------------------------------------
package divider_monitor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned LOCK_CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRST   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    // Increment that sticks at 'limit' once it has been reached.
    function automatic logic [LOCK_CNT_W-1:0] sat_inc(
        input logic [LOCK_CNT_W-1:0] value,
        input logic [LOCK_CNT_W-1:0] limit
    );
        return (value >= limit) ? limit : value + LOCK_CNT_W'(1);
    endfunction

endpackage

// File: rtl/divider_monitor_edge_sync.sv
// ----------------------------------------------------------------------------
// edge_sync
//
// Brings the asynchronous monitored clock into the system-clock domain with a
// two-flop synchronizer and keeps one extra history flop so that single-cycle
// rise and fall strobes can be derived from the synchronized level.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset (all flops cleared to 0)
//   async_in  monitored clock, asynchronous to clk
//   rise      one-cycle strobe: synchronized level went 0 -> 1
//   fall      one-cycle strobe: synchronized level went 1 -> 0
// ----------------------------------------------------------------------------
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign rise = sync2_q & ~hist_q;
    assign fall = ~sync2_q & hist_q;

endmodule

// File: rtl/divider_monitor.sv
// ----------------------------------------------------------------------------
// divider_monitor
//
// Measures a divided or external clock against the system clock. Reports the
// last complete period (rising edge to rising edge) and its high time in
// system-clock cycles, flags lock once enough consecutive periods agree, and
// flags a sticky timeout when the input stops producing rising edges.
//
// Ports:
//   i_SYS_CLOCK  system clock, all logic on its rising edge
//   i_RESET_N    asynchronous active-low reset
//   i_CLOCK_IN   monitored clock, asynchronous to i_SYS_CLOCK
//   i_CLEAR      synchronous clear back to IDLE with all outputs zeroed
//   o_PERIOD     last complete period in system cycles
//   o_HIGH_TIME  high time belonging to that period
//   o_VALID      one-cycle pulse, registered together with the measurements
//   o_LOCKED     LOCK_COUNT consecutive equal periods seen
//   o_TIMEOUT    sticky: no rising edge for TIMEOUT cycles
// ----------------------------------------------------------------------------
module divider_monitor
    import divider_monitor_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned TIMEOUT    = 32'h0010_0000
) (
    input  logic             i_SYS_CLOCK,
    input  logic             i_RESET_N,
    input  logic             i_CLOCK_IN,
    input  logic             i_CLEAR,
    output logic [WIDTH-1:0] o_PERIOD,
    output logic [WIDTH-1:0] o_HIGH_TIME,
    output logic             o_VALID,
    output logic             o_LOCKED,
    output logic             o_TIMEOUT
);

    localparam logic [WIDTH-1:0]      TIMEOUT_CNT = WIDTH'(TIMEOUT);
    localparam logic [LOCK_CNT_W-1:0] LOCK_MAX    = LOCK_CNT_W'(LOCK_COUNT);

    logic rise;
    logic fall;

    state_t                state_q,     state_d;
    logic [WIDTH-1:0]      count_q,     count_d;
    logic [WIDTH-1:0]      high_q,      high_d;
    logic [WIDTH-1:0]      prev_q,      prev_d;
    logic [LOCK_CNT_W-1:0] match_q,     match_d;
    logic [WIDTH-1:0]      period_q,    period_d;
    logic [WIDTH-1:0]      high_time_q, high_time_d;
    logic                  valid_q,     valid_d;
    logic                  locked_q,    locked_d;
    logic                  timeout_q,   timeout_d;

    logic                  timeout_hit;
    logic [LOCK_CNT_W-1:0] match_next;

    edge_sync u_edge_sync (
        .clk      (i_SYS_CLOCK),
        .rst_n    (i_RESET_N),
        .async_in (i_CLOCK_IN),
        .rise     (rise),
        .fall     (fall)
    );

    // The counter holds the pre-increment cycle count since the last rise,
    // so at the next rise it equals the period and at a fall the high time.
    assign timeout_hit = (count_q == TIMEOUT_CNT);

    // Match count the next reported period would produce: grows while
    // periods repeat, collapses to zero on any difference.
    assign match_next = (count_q == prev_q) ? sat_inc(match_q, LOCK_MAX)
                                            : '0;

    // Next-state logic. Clear beats everything; within an active measurement
    // a rise beats a simultaneous timeout, and a timeout beats a fall.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        high_d      = high_q;
        prev_d      = prev_q;
        match_d     = match_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;

        if (i_CLEAR) begin
            state_d     = IDLE;
            count_d     = '0;
            high_d      = '0;
            prev_d      = '0;
            match_d     = '0;
            period_d    = '0;
            high_time_d = '0;
            locked_d    = 1'b0;
            timeout_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    if (rise) begin
                        state_d = FIRST;
                        count_d = WIDTH'(1);
                        match_d = '0;
                    end
                end

                FIRST, MEASURE: begin
                    if (rise) begin
                        count_d = WIDTH'(1);
                        prev_d  = count_q;
                        if (state_q == FIRST) begin
                            // The period ending here is only a reference.
                            state_d = MEASURE;
                        end else begin
                            period_d    = count_q;
                            high_time_d = high_q;
                            valid_d     = 1'b1;
                            timeout_d   = 1'b0;
                            match_d     = match_next;
                            locked_d    = (match_next == LOCK_MAX);
                        end
                    end else if (timeout_hit) begin
                        // Stop counting so the counter can never wrap.
                        state_d   = IDLE;
                        count_d   = '0;
                        match_d   = '0;
                        locked_d  = 1'b0;
                        timeout_d = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                        if (fall) begin
                            high_d = count_q;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State and measurement registers; reset drops everything at once.
    always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_q     <= IDLE;
            count_q     <= '0;
            high_q      <= '0;
            prev_q      <= '0;
            match_q     <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            high_q      <= high_d;
            prev_q      <= prev_d;
            match_q     <= match_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_PERIOD    = period_q;
    assign o_HIGH_TIME = high_time_q;
    assign o_VALID     = valid_q;
    assign o_LOCKED    = locked_q;
    assign o_TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_divider_monitor.sv
// ----------------------------------------------------------------------------
// tb_divider_monitor
//
// Self-checking bench for divider_monitor. A timestamp-based model tracks
// when rising and falling edges of the monitored clock are seen (three system
// cycles after the pin) and derives period, high time, lock and timeout from
// the differences between those timestamps.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_divider_monitor;

    localparam int WIDTH      = 32;
    localparam int LOCK_COUNT = 4;
    localparam int TIMEOUT    = 64;

    localparam int M_IDLE    = 0;
    localparam int M_FIRST   = 1;
    localparam int M_MEASURE = 2;

    logic             sys_clock = 1'b0;
    logic             reset_n   = 1'b1;
    logic             clock_in  = 1'b0;
    logic             clear     = 1'b0;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             timeout;

    int compared   = 0;
    int mismatched = 0;
    int valid_seen = 0;
    bit checking   = 1'b0;

    int     m_phase     = M_IDLE;
    longint now_cycle   = 0;
    longint m_rise_at   = 0;
    longint m_period    = 0;
    longint m_high_time = 0;
    longint m_high_seen = 0;
    longint m_prev      = 0;
    int     m_match     = 0;
    bit     m_valid     = 1'b0;
    bit     m_locked    = 1'b0;
    bit     m_timeout   = 1'b0;
    bit     pin_d1      = 1'b0;
    bit     pin_d2      = 1'b0;
    bit     pin_d3      = 1'b0;
    bit     m_rise      = 1'b0;
    bit     m_fall      = 1'b0;

    divider_monitor #(
        .WIDTH      (WIDTH),
        .LOCK_COUNT (LOCK_COUNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_SYS_CLOCK (sys_clock),
        .i_RESET_N   (reset_n),
        .i_CLOCK_IN  (clock_in),
        .i_CLEAR     (clear),
        .o_PERIOD    (period),
        .o_HIGH_TIME (high_time),
        .o_VALID     (valid),
        .o_LOCKED    (locked),
        .o_TIMEOUT   (timeout)
    );

    always #5 sys_clock = ~sys_clock;

    // Compare one observed value against its expectation and tally it.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Drive 'reps' periods of the monitored clock, each 'high' cycles high
    // then 'per - high' cycles low, changing only on falling system edges.
    task automatic applyStimulus(input int per, input int high, input int reps);
        for (int r = 0; r < reps; r++) begin
            clock_in = 1'b1;
            repeat (high) @(negedge sys_clock);
            clock_in = 1'b0;
            repeat (per - high) @(negedge sys_clock);
        end
    endtask

    // Reference model. Edges of the pin become visible three system cycles
    // later; measurements are differences of edge timestamps.
    always @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase     = M_IDLE;
            m_period    = 0;
            m_high_time = 0;
            m_high_seen = 0;
            m_prev      = 0;
            m_match     = 0;
            m_valid     = 1'b0;
            m_locked    = 1'b0;
            m_timeout   = 1'b0;
            pin_d1      = 1'b0;
            pin_d2      = 1'b0;
            pin_d3      = 1'b0;
        end else begin
            now_cycle = now_cycle + 1;
            m_rise    = pin_d2 && !pin_d3;
            m_fall    = !pin_d2 && pin_d3;
            pin_d3    = pin_d2;
            pin_d2    = pin_d1;
            pin_d1    = clock_in;
            m_valid   = 1'b0;
            if (clear) begin
                m_phase     = M_IDLE;
                m_period    = 0;
                m_high_time = 0;
                m_high_seen = 0;
                m_prev      = 0;
                m_match     = 0;
                m_locked    = 1'b0;
                m_timeout   = 1'b0;
            end else if (m_phase == M_IDLE) begin
                if (m_rise) begin
                    m_phase   = M_FIRST;
                    m_rise_at = now_cycle;
                    m_match   = 0;
                end
            end else if (m_rise) begin
                if (m_phase == M_FIRST) begin
                    m_phase = M_MEASURE;
                end else begin
                    m_period    = now_cycle - m_rise_at;
                    m_high_time = m_high_seen;
                    m_valid     = 1'b1;
                    m_timeout   = 1'b0;
                    if (now_cycle - m_rise_at == m_prev)
                        m_match = (m_match + 1 > LOCK_COUNT) ? LOCK_COUNT : m_match + 1;
                    else
                        m_match = 0;
                    m_locked = (m_match >= LOCK_COUNT);
                end
                m_prev    = now_cycle - m_rise_at;
                m_rise_at = now_cycle;
            end else if (now_cycle - m_rise_at == TIMEOUT) begin
                m_phase   = M_IDLE;
                m_timeout = 1'b1;
                m_locked  = 1'b0;
                m_match   = 0;
            end else if (m_fall) begin
                m_high_seen = now_cycle - m_rise_at;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge sys_clock) begin
        if (checking) begin
            checkOutput("o_VALID",     valid,     m_valid);
            checkOutput("o_PERIOD",    period,    m_period);
            checkOutput("o_HIGH_TIME", high_time, m_high_time);
            checkOutput("o_LOCKED",    locked,    m_locked);
            checkOutput("o_TIMEOUT",   timeout,   m_timeout);
            if (valid) valid_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got time %0t, expected completion earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          v0;
        int          cyc;
        bit          got;
        int unsigned rp;
        int unsigned rh;
        int unsigned rn;

        #1 reset_n = 1'b0;
        checking = 1'b1;
        repeat (3) @(negedge sys_clock);
        checkOutput("reset_period", period, 0);
        checkOutput("reset_locked", locked, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge sys_clock);

        $display("[TB] steady 10/5 input");
        v0 = valid_seen;
        applyStimulus(10, 5, 8);
        checkOutput("valid_count_8_periods", valid_seen - v0, 6);
        checkOutput("steady_period", period, 10);
        checkOutput("steady_high", high_time, 5);
        checkOutput("steady_locked", locked, 1);

        $display("[TB] duty sweep at period 12");
        applyStimulus(12, 3, 8);
        checkOutput("duty3_period", period, 12);
        checkOutput("duty3_high", high_time, 3);
        checkOutput("duty3_locked", locked, 1);
        applyStimulus(12, 9, 6);
        checkOutput("duty9_period", period, 12);
        checkOutput("duty9_high", high_time, 9);
        checkOutput("duty9_locked", locked, 1);

        $display("[TB] single period glitch");
        applyStimulus(10, 5, 6);
        applyStimulus(11, 5, 1);
        applyStimulus(10, 5, 1);
        checkOutput("glitch_period", period, 11);
        checkOutput("glitch_locked", locked, 0);
        applyStimulus(10, 5, 5);
        checkOutput("relock_locked", locked, 1);

        $display("[TB] input stops high");
        clock_in = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge sys_clock);
            if (valid) got = 1'b1;
        end
        checkOutput("valid_before_timeout", got, 1);
        cyc = 0;
        while (!timeout && cyc < 200) begin
            @(negedge sys_clock);
            cyc++;
        end
        checkOutput("timeout_latency", cyc, TIMEOUT);
        checkOutput("timeout_locked", locked, 0);
        checkOutput("timeout_hold_period", period, 10);
        checkOutput("timeout_hold_high", high_time, 5);
        clock_in = 1'b0;
        repeat (5) @(negedge sys_clock);
        applyStimulus(10, 5, 3);
        checkOutput("recover_timeout", timeout, 0);
        checkOutput("recover_period", period, 10);

        $display("[TB] asynchronous reset mid-period");
        applyStimulus(10, 5, 6);
        clock_in = 1'b1;
        repeat (2) @(negedge sys_clock);
        @(posedge sys_clock);
        #3 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_period", period, 0);
        checkOutput("async_rst_high", high_time, 0);
        checkOutput("async_rst_locked", locked, 0);
        checkOutput("async_rst_valid", valid, 0);
        @(posedge sys_clock);
        #3 reset_n = 1'b1;
        @(negedge sys_clock);
        clock_in = 1'b0;
        repeat (4) @(negedge sys_clock);
        applyStimulus(10, 5, 6);
        checkOutput("post_rst_period", period, 10);
        checkOutput("post_rst_locked", locked, 1);

        $display("[TB] clear coinciding with a detected rise");
        clock_in = 1'b1;
        repeat (2) @(negedge sys_clock);
        clear = 1'b1;
        @(negedge sys_clock);
        clear = 1'b0;
        checkOutput("clear_period", period, 0);
        checkOutput("clear_high", high_time, 0);
        checkOutput("clear_locked", locked, 0);
        checkOutput("clear_valid", valid, 0);
        repeat (2) @(negedge sys_clock);
        clock_in = 1'b0;
        repeat (5) @(negedge sys_clock);
        applyStimulus(10, 5, 4);
        checkOutput("post_clear_period", period, 10);
        checkOutput("post_clear_locked", locked, 0);

        $display("[TB] minimum period 2");
        applyStimulus(2, 1, 12);
        repeat (2) @(negedge sys_clock);
        checkOutput("min_period", period, 2);
        checkOutput("min_high", high_time, 1);
        checkOutput("min_locked", locked, 1);

        $display("[TB] randomized segments");
        for (int seg = 0; seg < 24; seg++) begin
            rp = $urandom_range(40, 2);
            rh = $urandom_range(rp - 1, 1);
            rn = $urandom_range(6, 1);
            applyStimulus(int'(rp), int'(rh), int'(rn));
            if ($urandom_range(7, 0) == 0) begin
                clock_in = 1'b0;
                repeat (TIMEOUT + 10) @(negedge sys_clock);
            end
            if ($urandom_range(9, 0) == 0) begin
                clear = 1'b1;
                @(negedge sys_clock);
                clear = 1'b0;
            end
        end

        repeat (5) @(negedge sys_clock);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
